// File: rtl/core_fetch_pkg.sv
// core_fetch_pkg: types and constants shared by the fetch stage
// and its prefetch FIFO.
package core_fetch_pkg;

    localparam int PTR_W = 31;

    typedef logic [PTR_W-1:0] ptr_t;

    // Flush value; must match what decode treats as a no-op.
    localparam logic [15:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/core_fetch_fifo.sv
// core_fetch_fifo: small prefetch FIFO of {hword, pc} entries.
// Clear beats push and pop in the same cycle.
module core_fetch_fifo
    import core_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = PTR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [15:0]                i_hword,
    input  logic [AW-1:0]              i_pc,
    input  logic                       i_pop,
    output logic [15:0]                o_hword,
    output logic [AW-1:0]              o_pc,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   r_hw [DEPTH];
    logic [AW-1:0] r_pc [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_count = r_cnt;
    assign o_hword = r_hw[r_rd];
    assign o_pc    = r_pc[r_rd];

    assign w_pop  = i_pop && !o_empty && !i_clear;
    assign w_push = i_push && (!o_full || w_pop) && !i_clear;

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_hw[r_wr] <= i_hword;
            r_pc[r_wr] <= i_pc;
        end
    end

    // Read/write pointers and occupancy; push+pop leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/core_fetch.sv
// core_fetch: instruction fetch stage. Single outstanding halfword
// request, prefetch FIFO, registered insn output to decode.
module core_fetch
    import core_fetch_pkg::*;
#(
    parameter int                ADDR_W   = PTR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_start,
    input  logic              fetch_ready,
    input  logic [15:0]       fetch_data,
    output logic [15:0]       insn,
    output logic [ADDR_W-1:0] insn_pc,
    output logic              bubble
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic [15:0]       r_insn;
    logic [ADDR_W-1:0] r_insn_pc;
    logic              r_bubble;

    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [CW-1:0]     w_count;
    logic [15:0]       w_head_hw;
    logic [ADDR_W-1:0] w_head_pc;

    // Issue from IDLE only; occupancy is the registered count, so the
    // single in-flight response always has a free slot waiting for it.
    assign w_issue = !rst && (r_state == IDLE) && !branch
                     && (w_count < CW'(DEPTH));

    assign w_pop  = !stall && !branch && !w_empty;
    assign w_push = (r_state == WAIT) && fetch_ready && !branch
                    && (!w_full || w_pop);

    assign fetch_start = w_issue;
    assign fetch_addr  = r_pc;
    assign insn        = r_insn;
    assign insn_pc     = r_insn_pc;
    assign bubble      = r_bubble;

    core_fetch_fifo #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (branch),
        .i_push  (w_push),
        .i_hword (fetch_data),
        .i_pc    (r_req_pc),
        .i_pop   (w_pop),
        .o_hword (w_head_hw),
        .o_pc    (w_head_pc),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Request FSM and PC; a response arriving with a redirect still
    // completes the bus transaction, its data is simply not kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (branch) begin
                        r_pc <= target;
                    end else if (w_issue) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + ADDR_W'(1);
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (branch) begin
                        r_pc <= target;
                    end
                    if (fetch_ready) begin
                        r_state <= IDLE;
                    end else if (branch) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (branch) begin
                        r_pc <= target;
                    end
                    if (fetch_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Decode-facing register: redirect flushes, stall holds,
    // otherwise take the FIFO head or insert a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_insn    <= NOP;
            r_insn_pc <= '0;
            r_bubble  <= 1'b1;
        end else if (branch) begin
            r_insn   <= NOP;
            r_bubble <= 1'b1;
        end else if (!stall) begin
            if (!w_empty) begin
                r_insn    <= w_head_hw;
                r_insn_pc <= w_head_pc;
                r_bubble  <= 1'b0;
            end else begin
                r_insn   <= NOP;
                r_bubble <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: directed scenarios plus random stall/branch/latency
// traffic checked against a queue-based fetch model.
module tb_core_fetch;
    import core_fetch_pkg::*;

    localparam int AW    = 31;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [15:0]   hw;
        logic [AW-1:0] pc;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          branch;
    logic [AW-1:0] target;
    logic [AW-1:0] fetch_addr;
    logic          fetch_start;
    logic          fetch_ready;
    logic [15:0]   fetch_data;
    logic [15:0]   insn;
    logic [AW-1:0] insn_pc;
    logic          bubble;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t          m_q[$];
    logic          m_busy;
    logic          m_disc;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_req_pc;
    logic [15:0]   e_insn;
    logic [AW-1:0] e_pc;
    logic          e_bub;

    int            bus_cnt;
    logic [15:0]   bus_data;
    int            lat_min;
    int            lat_max;

    logic [AW-1:0] iss_log[$];
    ent_t          out_log[$];

    core_fetch #(
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch      (branch),
        .target      (target),
        .fetch_addr  (fetch_addr),
        .fetch_start (fetch_start),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .insn        (insn),
        .insn_pc     (insn_pc),
        .bubble      (bubble)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents: address 0 -> 1111, 1 -> 2222, ...
    function automatic logic [15:0] mem(input logic [AW-1:0] a);
        logic [15:0] t;
        t = a[15:0] + 16'd1;
        return t * 16'h1111;
    endfunction

    // One clock: drive at negedge, check issue, advance model, check outputs.
    task automatic step(input logic s, input logic b, input logic [AW-1:0] t);
        logic          rdy;
        logic          exp_start;
        logic          st;
        logic [AW-1:0] ad;
        ent_t          e;
        stall  = s;
        branch = b;
        target = t;
        rdy = (bus_cnt == 1);
        fetch_ready = rdy;
        fetch_data  = rdy ? bus_data : 16'hDEAD;
        #1;
        exp_start = !m_busy && !b && (m_q.size() < DEPTH);
        check("fetch_start", fetch_start, exp_start);
        if (exp_start) check("fetch_addr", fetch_addr, m_pc);
        st = fetch_start;
        ad = fetch_addr;
        if (st) iss_log.push_back(ad);
        @(posedge clk);
        if (bus_cnt > 0) bus_cnt--;
        if (st) begin
            bus_cnt  = $urandom_range(lat_max, lat_min);
            bus_data = mem(ad);
        end
        if (b) begin
            m_q.delete();
            e_insn = NOP;
            e_bub  = 1'b1;
        end else if (!s) begin
            if (m_q.size() > 0) begin
                e      = m_q.pop_front();
                e_insn = e.hw;
                e_pc   = e.pc;
                e_bub  = 1'b0;
            end else begin
                e_insn = NOP;
                e_bub  = 1'b1;
            end
        end
        if (m_busy && rdy) begin
            if (!m_disc && !b) m_q.push_back({fetch_data, m_req_pc});
            m_busy = 1'b0;
            m_disc = 1'b0;
        end else if (m_busy && b) begin
            m_disc = 1'b1;
        end
        if (exp_start) begin
            m_busy   = 1'b1;
            m_req_pc = m_pc;
            m_pc     = m_pc + AW'(1);
        end
        if (b) m_pc = t;
        #1;
        check("insn", insn, e_insn);
        check("bubble", bubble, e_bub);
        check("insn_pc", insn_pc, e_pc);
        if (!bubble) out_log.push_back({insn, insn_pc});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        branch = 1'b0;
        target = '0;
        fetch_ready = 1'b0;
        fetch_data = '0;
        bus_cnt = 0;
        bus_data = '0;
        lat_min = 1;
        lat_max = 1;
        m_busy = 1'b0;
        m_disc = 1'b0;
        m_pc = '0;
        m_req_pc = '0;
        e_insn = NOP;
        e_pc = '0;
        e_bub = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_start", fetch_start, 1'b0);
        check("rst_addr", fetch_addr, 0);
        check("rst_insn", insn, NOP);
        check("rst_insn_pc", insn_pc, 0);
        check("rst_bubble", bubble, 1'b1);
        rst = 1'b0;

        // Reset release, 1-cycle bus
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
        check("seq_n", out_log.size() >= 2, 1'b1);
        check("seq0_hw", out_log.size() > 0 ? out_log[0].hw : 'x, 16'h1111);
        check("seq0_pc", out_log.size() > 0 ? out_log[0].pc : 'x, 0);
        check("seq1_hw", out_log.size() > 1 ? out_log[1].hw : 'x, 16'h2222);
        check("seq1_pc", out_log.size() > 1 ? out_log[1].pc : 'x, 1);
        check("seq_addr2", iss_log.size() > 2 ? iss_log[2] : 'x, 2);

        // Stall held 5 cycles, then drain
        iss_log.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
        check("stall_issues", iss_log.size() <= DEPTH, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);

        // Branch to 0x40 while idle
        for (int k = 0; k < 8 && m_busy; k++) step(1'b1, 1'b0, '0);
        iss_log.delete();
        step(1'b0, 1'b1, AW'(32'h40));
        step(1'b0, 1'b0, '0);
        check("br_idle_addr", iss_log.size() > 0 ? iss_log[0] : 'x, 32'h40);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);

        // Branch during WAIT with 3-cycle bus
        lat_min = 3;
        lat_max = 3;
        for (int k = 0; k < 8 && !m_busy; k++) step(1'b0, 1'b0, '0);
        check("wait_busy", m_busy, 1'b1);
        out_log.delete();
        step(1'b0, 1'b1, AW'(32'h40));
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0);
        check("drop_first_pc", out_log.size() > 0 ? out_log[0].pc : 'x, 32'h40);

        // Branch coincident with fetch_ready and stall
        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 10 && bus_cnt != 1; k++) step(1'b0, 1'b0, '0);
        check("sync_ready", bus_cnt == 1, 1'b1);
        iss_log.delete();
        step(1'b1, 1'b1, AW'(32'h80));
        check("coin_bubble", bubble, 1'b1);
        step(1'b0, 1'b0, '0);
        check("coin_addr", iss_log.size() > 0 ? iss_log[0] : 'x, 32'h80);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);

        // PC wrap at the top of the address space
        iss_log.delete();
        step(1'b0, 1'b1, '1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
        check("wrap_top", iss_log.size() > 0 ? iss_log[0] : 'x, 32'h7FFF_FFFF);
        check("wrap_zero", iss_log.size() > 1 ? iss_log[1] : 'x, 0);

        // Random traffic
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            logic          rs;
            logic          rb;
            logic [AW-1:0] rt;
            rs = ($urandom_range(99, 0) < 30);
            rb = ($urandom_range(99, 0) < 7);
            if ($urandom_range(1, 0) == 1)
                rt = AW'($urandom_range(255, 0));
            else
                rt = '1 - AW'($urandom_range(3, 0));
            step(rs, rb, rt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
